// File: rtl/oflow_frame_seq_ctrl_if.sv
// Handshake and status bundle between the oflow frame sequencer and the DMA/FE, PE,
// conflict-resolve and MEM_buffer blocks. master = sequencer side, slave = environment side.
interface oflow_frame_seq_ctrl_if #(
    parameter int PE_NUM  = 24,
    parameter int BBOX_W  = 10,
    parameter int FRAME_W = 8
);
    localparam int PE_W = $clog2(PE_NUM + 1);

    logic                start;
    logic                new_frame;
    logic                ready_new_frame;
    logic [BBOX_W-1:0]   num_of_bbox_in_frame;
    logic                set_ready;
    logic                start_pe;
    logic [BBOX_W-1:0]   set_idx;
    logic [PE_W-1:0]     set_bbox_cnt;
    logic [BBOX_W-1:0]   num_of_sets;
    logic                done_pe;
    logic                start_cr;
    logic                done_cr;
    logic                conflict_counter_th;
    logic                start_write_mem;
    logic                rnw_st;
    logic                done_write;
    logic [FRAME_W-1:0]  frame_num;
    logic                valid_id;
    logic                frame_done;
    logic                busy;
    logic [31:0]         frame_cycles;

    modport master (
        input  start, new_frame, num_of_bbox_in_frame, set_ready, done_pe,
               done_cr, conflict_counter_th, done_write,
        output ready_new_frame, start_pe, set_idx, set_bbox_cnt, num_of_sets,
               start_cr, start_write_mem, rnw_st, frame_num, valid_id,
               frame_done, busy, frame_cycles
    );

    modport slave (
        output start, new_frame, num_of_bbox_in_frame, set_ready, done_pe,
               done_cr, conflict_counter_th, done_write,
        input  ready_new_frame, start_pe, set_idx, set_bbox_cnt, num_of_sets,
               start_cr, start_write_mem, rnw_st, frame_num, valid_id,
               frame_done, busy, frame_cycles
    );
endinterface

// File: rtl/oflow_frame_seq_ctrl.sv
// oflow frame sequencer: set split by a BBOX_W-cycle restoring divider, per-set PE handshakes,
// CR/WRITE routing and frame counter. Optional cycle counter: OFLOW_FSM_PERF_CNT_EN.
module oflow_frame_seq_ctrl #(
    parameter int PE_NUM  = 24,
    parameter int BBOX_W  = 10,
    parameter int FRAME_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_N,
    oflow_frame_seq_ctrl_if.master        bus
);
    localparam int PE_W   = $clog2(PE_NUM + 1);
    localparam int DIV_W  = PE_W + 1;
    localparam int STEP_W = $clog2(BBOX_W + 1);
    localparam logic [DIV_W-1:0]  PE_NUM_D  = DIV_W'(PE_NUM);
    localparam logic [PE_W-1:0]   PE_NUM_P  = PE_W'(PE_NUM);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BBOX_W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        SET_WAIT = 3'd2,
        PE_RUN   = 3'd3,
        CR       = 3'd4,
        WRITE    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [BBOX_W-1:0]   quo_q, quo_d;
    logic [PE_W-1:0]     rem_q, rem_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                cnt_zero_q, cnt_zero_d;
    logic [BBOX_W-1:0]   sets_q, sets_d;
    logic [BBOX_W-1:0]   set_idx_q, set_idx_d;
    logic [PE_W-1:0]     last_cnt_q, last_cnt_d;
    logic [PE_W-1:0]     set_cnt_q, set_cnt_d;
    logic [FRAME_W-1:0]  frame_num_q, frame_num_d;
    logic                valid_id_q;
    logic                start_pe_s, start_cr_s, start_wr_s, frame_done_s;

    logic [DIV_W-1:0]    trial_s, rem_step_s;
    logic [BBOX_W-1:0]   quo_step_s;
    logic                ge_s, rem_nz_s;

    // Frame 0 is reserved for the first frame after start, so the counter wraps to 1.
    function automatic logic [FRAME_W-1:0] frame_inc(input logic [FRAME_W-1:0] fn);
        if (fn == {FRAME_W{1'b1}}) begin
            return FRAME_W'(1);
        end else begin
            return fn + FRAME_W'(1);
        end
    endfunction

    // Dividend bits shift out of quo_q MSB-first while quotient bits shift in at the LSB.
    assign trial_s    = {rem_q, quo_q[BBOX_W-1]};
    assign ge_s       = (trial_s >= PE_NUM_D);
    assign rem_step_s = ge_s ? (trial_s - PE_NUM_D) : trial_s;
    assign quo_step_s = {quo_q[BBOX_W-2:0], ge_s};
    assign rem_nz_s   = |rem_step_s;

    // Next-state, datapath updates and transition pulses.
    always_comb begin
        state_d      = state_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        step_d       = step_q;
        cnt_zero_d   = cnt_zero_q;
        sets_d       = sets_q;
        set_idx_d    = set_idx_q;
        last_cnt_d   = last_cnt_q;
        set_cnt_d    = set_cnt_q;
        frame_num_d  = frame_num_q;
        start_pe_s   = 1'b0;
        start_cr_s   = 1'b0;
        start_wr_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start || bus.new_frame) begin
                    state_d    = CALC;
                    quo_d      = bus.num_of_bbox_in_frame;
                    rem_d      = '0;
                    step_d     = '0;
                    cnt_zero_d = (bus.num_of_bbox_in_frame == '0);
                    if (bus.start) begin
                        frame_num_d = '0;
                    end else begin
                        frame_num_d = frame_num_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                quo_d  = quo_step_s;
                rem_d  = rem_step_s[PE_W-1:0];
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    sets_d     = quo_step_s + {{(BBOX_W-1){1'b0}}, rem_nz_s};
                    last_cnt_d = rem_nz_s ? rem_step_s[PE_W-1:0] : PE_NUM_P;
                    set_idx_d  = '0;
                    if (cnt_zero_q) begin
                        state_d      = IDLE;
                        frame_done_s = 1'b1;
                        frame_num_d  = frame_inc(frame_num_q);
                    end else begin
                        state_d   = SET_WAIT;
                        set_cnt_d = (sets_d > BBOX_W'(1)) ? PE_NUM_P : last_cnt_d;
                    end
                end else begin
                    state_d = CALC;
                end
            end
            SET_WAIT: begin
                if (bus.set_ready) begin
                    start_pe_s = 1'b1;
                    state_d    = PE_RUN;
                end else begin
                    state_d = SET_WAIT;
                end
            end
            PE_RUN: begin
                if (!bus.done_pe) begin
                    state_d = PE_RUN;
                end else if (set_idx_q < (sets_q - BBOX_W'(1))) begin
                    set_idx_d = set_idx_q + BBOX_W'(1);
                    set_cnt_d = (set_idx_d < (sets_q - BBOX_W'(1))) ? PE_NUM_P : last_cnt_q;
                    state_d   = SET_WAIT;
                end else if (frame_num_q == '0) begin
                    start_wr_s = 1'b1;
                    state_d    = WRITE;
                end else begin
                    start_cr_s = 1'b1;
                    state_d    = CR;
                end
            end
            CR: begin
                if (bus.conflict_counter_th) begin
                    state_d     = IDLE;
                    frame_num_d = '0;
                end else if (bus.done_cr) begin
                    start_wr_s = 1'b1;
                    state_d    = WRITE;
                end else begin
                    state_d = CR;
                end
            end
            WRITE: begin
                if (bus.done_write) begin
                    state_d      = IDLE;
                    frame_done_s = 1'b1;
                    frame_num_d  = frame_inc(frame_num_q);
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            step_q      <= '0;
            cnt_zero_q  <= 1'b0;
            sets_q      <= '0;
            set_idx_q   <= '0;
            last_cnt_q  <= '0;
            set_cnt_q   <= '0;
            frame_num_q <= '0;
            valid_id_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            step_q      <= step_d;
            cnt_zero_q  <= cnt_zero_d;
            sets_q      <= sets_d;
            set_idx_q   <= set_idx_d;
            last_cnt_q  <= last_cnt_d;
            set_cnt_q   <= set_cnt_d;
            frame_num_q <= frame_num_d;
            valid_id_q  <= (state_d == WRITE) && (state_q != WRITE);
        end
    end

`ifdef OFLOW_FSM_PERF_CNT_EN
    logic [31:0] cyc_q, frame_cycles_q, cyc_inc_s;

    assign cyc_inc_s = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : (cyc_q + 32'd1);

    // Non-IDLE cycle count of the current frame, captured on frame_done.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            cyc_q          <= 32'd0;
            frame_cycles_q <= 32'd0;
        end else begin
            cyc_q <= (state_q == IDLE) ? 32'd0 : cyc_inc_s;
            if (frame_done_s) begin
                frame_cycles_q <= cyc_inc_s;
            end else begin
                frame_cycles_q <= frame_cycles_q;
            end
        end
    end

    assign bus.frame_cycles = frame_cycles_q;
`else
    assign bus.frame_cycles = 32'd0;
`endif

    assign bus.ready_new_frame = (state_q == IDLE);
    assign bus.busy            = (state_q != IDLE);
    assign bus.rnw_st          = (state_q != WRITE);
    assign bus.start_pe        = start_pe_s;
    assign bus.start_cr        = start_cr_s;
    assign bus.start_write_mem = start_wr_s;
    assign bus.frame_done      = frame_done_s;
    assign bus.valid_id        = valid_id_q;
    assign bus.set_idx         = set_idx_q;
    assign bus.set_bbox_cnt    = set_cnt_q;
    assign bus.num_of_sets     = sets_q;
    assign bus.frame_num       = frame_num_q;
endmodule

// File: tb/tb_oflow_frame_seq_ctrl.sv
// Randomized self-checking bench for oflow_frame_seq_ctrl; expectations come from a
// frame-level model (ceil-division set split, frame counter with wrap to 1).
module tb_oflow_frame_seq_ctrl;
    localparam int PE_NUM  = 24;
    localparam int BBOX_W  = 10;
    localparam int FRAME_W = 8;
    localparam int MAX_FN  = (1 << FRAME_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oflow_frame_seq_ctrl_if #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W)) bus();

    oflow_frame_seq_ctrl #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W)) dut (
        .clk     (clk),
        .reset_N (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_fn = 0;

    // {ready_new_frame, busy, start_pe, start_cr, start_write_mem, frame_done, valid_id, rnw_st}
    logic [7:0] obs_v;
    assign obs_v = {bus.ready_new_frame, bus.busy, bus.start_pe, bus.start_cr,
                    bus.start_write_mem, bus.frame_done, bus.valid_id, bus.rnw_st};

    task automatic clear_inputs();
        bus.start = 1'b0;
        bus.new_frame = 1'b0;
        bus.num_of_bbox_in_frame = '0;
        bus.set_ready = 1'b0;
        bus.done_pe = 1'b0;
        bus.done_cr = 1'b0;
        bus.conflict_counter_th = 1'b0;
        bus.done_write = 1'b0;
    endtask

    function automatic int next_fn(input int fn);
        return (fn == MAX_FN) ? 1 : fn + 1;
    endfunction

    // One complete frame, checked cycle by cycle against the frame-level model.
    task automatic run_frame(input int n, input bit use_start, input bit abort_cr);
        int sets, exp_cnt, d;
        bit last, aborted;
        logic [7:0] exp_v;
        aborted = 1'b0;
        @(negedge clk);
        clear_inputs();
        bus.num_of_bbox_in_frame = BBOX_W'(n);
        bus.start = use_start;
        bus.new_frame = use_start ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        n_cmp++;
        if (obs_v !== 8'b1000_0001) begin
            n_bad++;
            $display("FAIL idle_status n=%0d: got %b want 10000001", n, obs_v);
        end
        if (use_start) mdl_fn = 0;
        sets = (n + PE_NUM - 1) / PE_NUM;
        for (int c = 1; c <= BBOX_W; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.start = 1'($urandom_range(0, 1));
            bus.new_frame = 1'($urandom_range(0, 1));
            bus.num_of_bbox_in_frame = BBOX_W'($urandom);
            bus.done_pe = 1'($urandom_range(0, 1));
            #1;
            exp_v = {2'b01, 3'b000, (n == 0 && c == BBOX_W), 2'b01};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL calc n=%0d cyc=%0d: got %b want %b", n, c, obs_v, exp_v);
            end
        end
        for (int s = 0; s < sets; s++) begin
            exp_cnt = (s < sets - 1) ? PE_NUM : n - PE_NUM * (sets - 1);
            last = (s == sets - 1);
            d = $urandom_range(0, 2);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                clear_inputs();
                bus.set_ready = (k == d);
                bus.done_pe = (k != d) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.start = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if (int'(bus.set_idx) !== s || int'(bus.set_bbox_cnt) !== exp_cnt ||
                    int'(bus.num_of_sets) !== sets) begin
                    n_bad++;
                    $display("FAIL set_info n=%0d: got idx=%0d cnt=%0d sets=%0d want idx=%0d cnt=%0d sets=%0d",
                             n, bus.set_idx, bus.set_bbox_cnt, bus.num_of_sets, s, exp_cnt, sets);
                end
                exp_v = {2'b01, (k == d), 5'b00001};
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL set_wait n=%0d set=%0d: got %b want %b", n, s, obs_v, exp_v);
                end
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                clear_inputs();
                bus.set_ready = 1'($urandom_range(0, 1));
                bus.start = 1'($urandom_range(0, 1));
                bus.done_pe = (k == d);
                #1;
                exp_v = {2'b01, 1'b0, (k == d && last && mdl_fn != 0),
                         (k == d && last && mdl_fn == 0), 3'b001};
                n_cmp++;
                if (obs_v !== exp_v || int'(bus.set_bbox_cnt) !== exp_cnt) begin
                    n_bad++;
                    $display("FAIL pe_run n=%0d set=%0d: got %b cnt=%0d want %b cnt=%0d",
                             n, s, obs_v, bus.set_bbox_cnt, exp_v, exp_cnt);
                end
            end
        end
        if (sets > 0 && mdl_fn != 0) begin
            d = $urandom_range(0, 2);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                clear_inputs();
                bus.done_pe = 1'($urandom_range(0, 1));
                bus.done_cr = (k == d);
                bus.conflict_counter_th = (k == d) && abort_cr;
                #1;
                exp_v = {2'b01, 2'b00, (k == d && !abort_cr), 3'b001};
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cr n=%0d abort=%0d: got %b want %b", n, abort_cr, obs_v, exp_v);
                end
            end
            if (abort_cr) begin
                aborted = 1'b1;
                mdl_fn = 0;
            end
        end
        if (sets > 0 && !aborted) begin
            d = $urandom_range(0, 2);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                clear_inputs();
                bus.done_write = (k == d);
                #1;
                exp_v = {2'b01, 3'b000, (k == d), (k == 0), 1'b0};
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL write n=%0d cyc=%0d: got %b want %b", n, k, obs_v, exp_v);
                end
            end
        end
        if (!aborted) mdl_fn = next_fn(mdl_fn);
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (obs_v !== 8'b1000_0001 || int'(bus.frame_num) !== mdl_fn) begin
            n_bad++;
            $display("FAIL frame_end n=%0d: got %b fn=%0d want 10000001 fn=%0d",
                     n, obs_v, bus.frame_num, mdl_fn);
        end
`ifndef OFLOW_FSM_PERF_CNT_EN
        n_cmp++;
        if (bus.frame_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL frame_cycles: got %0d want 0", bus.frame_cycles);
        end
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs_v !== 8'b1000_0001 || bus.set_idx !== '0 || bus.set_bbox_cnt !== '0 ||
            bus.num_of_sets !== '0 || bus.frame_num !== '0) begin
            n_bad++;
            $display("FAIL reset: got %b idx=%0d cnt=%0d sets=%0d fn=%0d want 10000001 all zero",
                     obs_v, bus.set_idx, bus.set_bbox_cnt, bus.num_of_sets, bus.frame_num);
        end
        rst_n = 1'b1;
        mdl_fn = 0;
    endtask

    task automatic test_write_path();
        run_frame(50, 1'b1, 1'b0);
    endtask

    task automatic test_cr_path();
        run_frame(48, 1'b0, 1'b0);
    endtask

    task automatic test_zero_count();
        run_frame(0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_frame($urandom_range(1, 100), 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 300 && mdl_fn != MAX_FN; i++) run_frame(0, 1'b0, 1'b0);
        run_frame($urandom_range(1, 60), 1'b0, 1'b0);
        run_frame($urandom_range(1, 60), 1'b0, 1'b0);
    endtask

    task automatic test_boundaries();
        run_frame((1 << BBOX_W) - 1, 1'b0, 1'b0);
        run_frame(PE_NUM, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(PE_NUM + 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_frame($urandom_range(0, 200), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 4) == 0));
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        clear_inputs();
        bus.new_frame = 1'b1;
        bus.num_of_bbox_in_frame = BBOX_W'(50);
        repeat (BBOX_W) begin
            @(negedge clk);
            clear_inputs();
        end
        @(negedge clk);
        bus.set_ready = 1'b1;
        @(negedge clk);
        bus.set_ready = 1'b0;
        bus.done_pe = 1'b1;
        @(negedge clk);
        bus.done_pe = 1'b0;
        bus.set_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || int'(bus.set_idx) !== 1) begin
            n_bad++;
            $display("FAIL midrun_pre: got busy=%b idx=%0d want busy=1 idx=1", bus.busy, bus.set_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_v !== 8'b1000_0001 || bus.set_idx !== '0 || bus.set_bbox_cnt !== '0 ||
            bus.num_of_sets !== '0 || bus.frame_num !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: got %b idx=%0d cnt=%0d sets=%0d fn=%0d want 10000001 all zero",
                     obs_v, bus.set_idx, bus.set_bbox_cnt, bus.num_of_sets, bus.frame_num);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_fn = 0;
        run_frame(30, 1'b1, 1'b0);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_path();
        test_cr_path();
        test_zero_count();
        test_abort();
        test_wrap();
        test_boundaries();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
